// File: rtl/l1_ahb_mtx_pkg.sv
// Shared AHB encodings for the bus-matrix input/output stages.
package l1_ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic {
    HR_OKAY  = 1'b0,
    HR_ERROR = 1'b1
  } hresp_e;

  // NONSEQ and SEQ both carry bit 1; IDLE/BUSY never request a slave.
  function automatic logic trans_is_xfer(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/l1_ahb_mtx_hold_reg.sv
// Address-phase holding register and live/held output mux for one input port.
// Optional: L1_AHB_MTX_IN_STG_BURST_RECODE_EN recodes a held SEQ as NONSEQ/INCR.
module l1_ahb_mtx_hold_reg
  import l1_ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_load,
  input  logic              i_pend,
  input  logic              i_live_vld,
  input  logic              i_sel,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_trans,
  input  logic              i_write,
  input  logic [2:0]        i_size,
  input  logic [2:0]        i_burst,
  input  logic [3:0]        i_prot,
  input  logic [MST_W-1:0]  i_master,
  input  logic              i_mastlock,
  output logic              o_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_trans,
  output logic              o_write,
  output logic [2:0]        o_size,
  output logic [2:0]        o_burst,
  output logic [3:0]        o_prot,
  output logic [MST_W-1:0]  o_master,
  output logic              o_mastlock
);

  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [3:0]        r_prot;
  logic [MST_W-1:0]  r_master;
  logic              r_mastlock;
  logic              w_recode;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_trans    <= HT_IDLE;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_burst    <= HB_SINGLE;
      r_prot     <= '0;
      r_master   <= '0;
      r_mastlock <= 1'b0;
    end else if (i_load) begin
      r_sel      <= i_sel;
      r_addr     <= i_addr;
      r_trans    <= i_trans;
      r_write    <= i_write;
      r_size     <= i_size;
      r_burst    <= i_burst;
      r_prot     <= i_prot;
      r_master   <= i_master;
      r_mastlock <= i_mastlock;
    end
  end

`ifdef L1_AHB_MTX_IN_STG_BURST_RECODE_EN
  // A burst that lost arbitration mid-way restarts as an undefined-length INCR.
  assign w_recode = i_pend & (r_trans == HT_SEQ);
`else
  assign w_recode = 1'b0;
`endif

  always_comb begin
    o_sel      = i_sel;
    o_addr     = i_addr;
    o_trans    = i_live_vld ? i_trans : HT_IDLE;
    o_write    = i_write;
    o_size     = i_size;
    o_burst    = i_burst;
    o_prot     = i_prot;
    o_master   = i_master;
    o_mastlock = i_mastlock;
    if (i_pend) begin
      o_sel      = r_sel;
      o_addr     = r_addr;
      o_trans    = w_recode ? HT_NONSEQ : r_trans;
      o_write    = r_write;
      o_size     = r_size;
      o_burst    = w_recode ? HB_INCR : r_burst;
      o_prot     = r_prot;
      o_master   = r_master;
      o_mastlock = r_mastlock;
    end
  end

endmodule

// File: rtl/l1_ahb_mtx_in_stg.sv
// Bus-matrix input stage: holds an ungranted address phase and returns the
// granted output stage's data-phase response. Option: L1_AHB_MTX_IN_STG_BURST_RECODE_EN.
module l1_ahb_mtx_in_stg
  import l1_ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic [MST_W-1:0]  HMASTERS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  input  logic              active_ip,
  input  logic              readyout_ip,
  input  logic              resp_ip,
  output logic              sel_ip,
  output logic [ADDR_W-1:0] addr_ip,
  output logic [1:0]        trans_ip,
  output logic              write_ip,
  output logic [2:0]        size_ip,
  output logic [2:0]        burst_ip,
  output logic [3:0]        prot_ip,
  output logic [MST_W-1:0]  master_ip,
  output logic              mastlock_ip,
  output logic              held_tran_ip
);

  logic r_pend;
  logic r_dphase;
  logic w_live_vld;
  logic w_trans_valid;
  logic w_accept;
  logic w_dph_upd;

  assign w_live_vld    = HSELS & HREADYS;
  assign w_trans_valid = w_live_vld & trans_is_xfer(HTRANSS);
  assign held_tran_ip  = r_pend | w_trans_valid;
  assign w_accept      = active_ip & readyout_ip & held_tran_ip;

  // A held address phase completes while HREADYOUTS is low, so pend also
  // opens the window for capturing data-phase ownership.
  assign w_dph_upd = HREADYOUTS | r_pend;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend   <= 1'b0;
      r_dphase <= 1'b0;
    end else begin
      if (w_accept)           r_pend <= 1'b0;
      else if (w_trans_valid) r_pend <= 1'b1;
      if (w_dph_upd)          r_dphase <= w_accept;
    end
  end

  assign HREADYOUTS = r_dphase ? readyout_ip : ~r_pend;
  assign HRESPS     = r_dphase ? resp_ip : HR_OKAY;

  l1_ahb_mtx_hold_reg #(
    .ADDR_W (ADDR_W),
    .MST_W  (MST_W)
  ) u_hold (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .i_load     (w_live_vld),
    .i_pend     (r_pend),
    .i_live_vld (w_live_vld),
    .i_sel      (HSELS),
    .i_addr     (HADDRS),
    .i_trans    (HTRANSS),
    .i_write    (HWRITES),
    .i_size     (HSIZES),
    .i_burst    (HBURSTS),
    .i_prot     (HPROTS),
    .i_master   (HMASTERS),
    .i_mastlock (HMASTLOCKS),
    .o_sel      (sel_ip),
    .o_addr     (addr_ip),
    .o_trans    (trans_ip),
    .o_write    (write_ip),
    .o_size     (size_ip),
    .o_burst    (burst_ip),
    .o_prot     (prot_ip),
    .o_master   (master_ip),
    .o_mastlock (mastlock_ip)
  );

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
// Table-driven bench for l1_ahb_mtx_in_stg with a scoreboard queue of expected outputs.
module tb_l1_ahb_mtx_in_stg;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        active_ip;
  logic        readyout_ip;
  logic        resp_ip;
  logic        sel_ip;
  logic [31:0] addr_ip;
  logic [1:0]  trans_ip;
  logic        write_ip;
  logic [2:0]  size_ip;
  logic [2:0]  burst_ip;
  logic [3:0]  prot_ip;
  logic [3:0]  master_ip;
  logic        mastlock_ip;
  logic        held_tran_ip;

  always #5 HCLK = ~HCLK;

  l1_ahb_mtx_in_stg #(.ADDR_W(32), .MST_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip), .write_ip(write_ip),
    .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
    .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip)
  );

`ifdef L1_AHB_MTX_IN_STG_BURST_RECODE_EN
  localparam logic [1:0] RC_TR = 2'b10;
  localparam logic [2:0] RC_BU = 3'b001;
`else
  localparam logic [1:0] RC_TR = 2'b11;
  localparam logic [2:0] RC_BU = 3'b011;
`endif

  typedef struct {
    logic        sel, hrdy;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic [2:0]  bu;
    logic        act, rdy, rsp;
    logic        e_held;
    logic [1:0]  e_tr;
    logic [31:0] e_ad;
    logic [2:0]  e_bu;
    logic        e_rdyo, e_rsp;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];
  vec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic sel, logic hrdy, logic [1:0] tr, logic [31:0] ad,
                              logic [2:0] bu, logic act, logic rdy, logic rsp,
                              logic e_held, logic [1:0] e_tr, logic [31:0] e_ad,
                              logic [2:0] e_bu, logic e_rdyo, logic e_rsp);
    vec_t v;
    v.sel = sel; v.hrdy = hrdy; v.tr = tr; v.ad = ad; v.bu = bu;
    v.act = act; v.rdy = rdy; v.rsp = rsp;
    v.e_held = e_held; v.e_tr = e_tr; v.e_ad = e_ad; v.e_bu = e_bu;
    v.e_rdyo = e_rdyo; v.e_rsp = e_rsp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    // Row: sel hrdy trans addr burst act rdy rsp | held trans addr burst rdyo rsp
    tbl[0]  = mk(0,1,2'd0,32'h0,3'd0,0,1,0,        0,2'd0,32'h0,3'd0,1,0);
    tbl[1]  = mk(1,1,2'd2,32'h1000_0000,3'd0,1,1,0, 1,2'd2,32'h1000_0000,3'd0,1,0);
    tbl[2]  = mk(0,1,2'd0,32'h0,3'd0,0,1,0,        0,2'd0,32'h0,3'd0,1,0);
    tbl[3]  = mk(1,1,2'd2,32'h2000_0010,3'd0,0,1,0, 1,2'd2,32'h2000_0010,3'd0,1,0);
    tbl[4]  = mk(1,0,2'd2,32'h3000_0000,3'd0,0,1,0, 1,2'd2,32'h2000_0010,3'd0,0,0);
    tbl[5]  = mk(1,0,2'd2,32'h3000_0004,3'd0,0,1,0, 1,2'd2,32'h2000_0010,3'd0,0,0);
    tbl[6]  = mk(1,0,2'd2,32'h3000_0008,3'd0,0,1,0, 1,2'd2,32'h2000_0010,3'd0,0,0);
    tbl[7]  = mk(1,0,2'd2,32'h3000_0008,3'd0,1,1,0, 1,2'd2,32'h2000_0010,3'd0,0,0);
    tbl[8]  = mk(0,0,2'd0,32'h0,3'd0,0,0,0,        0,2'd0,32'h0,3'd0,0,0);
    tbl[9]  = mk(0,0,2'd0,32'h0,3'd0,0,0,0,        0,2'd0,32'h0,3'd0,0,0);
    tbl[10] = mk(0,1,2'd0,32'h0,3'd0,0,1,0,        0,2'd0,32'h0,3'd0,1,0);
    tbl[11] = mk(1,1,2'd2,32'h4000_0000,3'd0,1,1,0, 1,2'd2,32'h4000_0000,3'd0,1,0);
    tbl[12] = mk(0,0,2'd0,32'h0,3'd0,0,0,1,        0,2'd0,32'h0,3'd0,0,1);
    tbl[13] = mk(0,1,2'd0,32'h0,3'd0,0,1,1,        0,2'd0,32'h0,3'd0,1,1);
    tbl[14] = mk(0,1,2'd0,32'h0,3'd0,0,1,1,        0,2'd0,32'h0,3'd0,1,0);
    tbl[15] = mk(1,1,2'd3,32'h5000_0004,3'd3,0,1,0, 1,2'd3,32'h5000_0004,3'd3,1,0);
    tbl[16] = mk(1,0,2'd3,32'h5000_0008,3'd3,0,1,0, 1,RC_TR,32'h5000_0004,RC_BU,0,0);
    tbl[17] = mk(1,0,2'd3,32'h5000_0008,3'd3,1,1,0, 1,RC_TR,32'h5000_0004,RC_BU,0,0);
    tbl[18] = mk(0,1,2'd0,32'h0,3'd0,0,1,0,        0,2'd0,32'h0,3'd0,1,0);
    tbl[19] = mk(1,1,2'd1,32'h6000_0000,3'd1,0,1,0, 0,2'd1,32'h6000_0000,3'd1,1,0);
    tbl[20] = mk(0,1,2'd0,32'h0,3'd0,0,1,0,        0,2'd0,32'h0,3'd0,1,0);

    HRESETn = 1'b0; HSELS = 0; HADDRS = '0; HTRANSS = 2'd0; HWRITES = 0;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTERS = 4'h5; HMASTLOCKS = 0;
    HREADYS = 1; active_ip = 0; readyout_ip = 1; resp_ip = 0;
    #2;
    chk("rst_held", {31'b0, held_tran_ip}, 32'd0);
    chk("rst_rdyo", {31'b0, HREADYOUTS}, 32'd1);
    chk("rst_resp", {31'b0, HRESPS}, 32'd0);
    chk("rst_trans", {30'b0, trans_ip}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge HCLK); #1;
      HSELS = tbl[i].sel; HREADYS = tbl[i].hrdy; HTRANSS = tbl[i].tr;
      HADDRS = tbl[i].ad; HBURSTS = tbl[i].bu; active_ip = tbl[i].act;
      readyout_ip = tbl[i].rdy; resp_ip = tbl[i].rsp;
      sb.push_back(tbl[i]);
      @(negedge HCLK);
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d_held", i),  {31'b0, held_tran_ip}, {31'b0, e.e_held});
        chk($sformatf("v%0d_trans", i), {30'b0, trans_ip},     {30'b0, e.e_tr});
        chk($sformatf("v%0d_addr", i),  addr_ip,               e.e_ad);
        chk($sformatf("v%0d_burst", i), {29'b0, burst_ip},     {29'b0, e.e_bu});
        chk($sformatf("v%0d_rdyo", i),  {31'b0, HREADYOUTS},   {31'b0, e.e_rdyo});
        chk($sformatf("v%0d_resp", i),  {31'b0, HRESPS},       {31'b0, e.e_rsp});
      end
    end

    // Locked, ungranted write held while live inputs move, then async reset.
    @(posedge HCLK); #1;
    HSELS = 1; HREADYS = 1; HTRANSS = 2'd2; HADDRS = 32'h7000_0000; HBURSTS = 3'd0;
    HWRITES = 1; HMASTLOCKS = 1; HSIZES = 3'd1; HPROTS = 4'hA; HMASTERS = 4'h9;
    active_ip = 0; readyout_ip = 1; resp_ip = 0;
    @(negedge HCLK);
    chk("lk_held0", {31'b0, held_tran_ip}, 32'd1);
    @(posedge HCLK); #1;
    HREADYS = 0; HADDRS = 32'h7100_0000; HWRITES = 0; HMASTLOCKS = 0;
    HSIZES = 3'd2; HPROTS = 4'h3; HMASTERS = 4'h5;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("lk_rdyo",   {31'b0, HREADYOUTS}, 32'd0);
    chk("lk_lock",   {31'b0, mastlock_ip}, 32'd1);
    chk("lk_write",  {31'b0, write_ip}, 32'd1);
    chk("lk_addr",   addr_ip, 32'h7000_0000);
    chk("lk_size",   {29'b0, size_ip}, 32'd1);
    chk("lk_prot",   {28'b0, prot_ip}, 32'hA);
    chk("lk_master", {28'b0, master_ip}, 32'h9);
    chk("lk_sel",    {31'b0, sel_ip}, 32'd1);
    #1 HRESETn = 1'b0;
    #1;
    chk("ar_held", {31'b0, held_tran_ip}, 32'd0);
    chk("ar_rdyo", {31'b0, HREADYOUTS}, 32'd1);
    chk("ar_resp", {31'b0, HRESPS}, 32'd0);
    chk("ar_trans", {30'b0, trans_ip}, 32'd0);
    chk("ar_addr", addr_ip, 32'h7100_0000);
    @(negedge HCLK);
    HRESETn = 1'b1; HSELS = 0; HREADYS = 1;
    @(negedge HCLK);
    chk("post_rdyo", {31'b0, HREADYOUTS}, 32'd1);
    chk("post_held", {31'b0, held_tran_ip}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
